// File: rtl/stc_dispatch.sv
// Tile dispatcher for a bank of sparse tensor cores: hands operand beats to
// cores round-robin and returns their results in dispatch order.
// Optional: STC_DISPATCH_PERF_EN adds perf_tiles / perf_stall counters.
module stc_dispatch #(
    parameter int NUM_CORES   = 4,
    parameter int A_W         = 512,
    parameter int B_W         = 256,
    parameter int C_W         = 512,
    parameter int IDX_W       = 128,
    parameter int R_W         = 512,
    parameter int FETCH_BEATS = 1,
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int OW = $clog2(NUM_CORES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [A_W-1:0]           a_data_in,
    input  logic [B_W-1:0]           b_data_in,
    input  logic [C_W-1:0]           c_data_in,
    input  logic [IDX_W-1:0]         weight_idx_in,
    input  logic [NUM_CORES-1:0]     core_idle,
    input  logic [NUM_CORES-1:0]     core_fetch,
    input  logic [NUM_CORES-1:0]     core_wb,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES-1:0]     core_fetch_done,
    output logic [NUM_CORES-1:0]     core_load,
    output logic [NUM_CORES-1:0]     core_wb_ack,
    output logic [A_W-1:0]           a_data_out,
    output logic [B_W-1:0]           b_data_out,
    output logic [C_W-1:0]           c_data_out,
    output logic [IDX_W-1:0]         weight_idx_out,
    input  logic [NUM_CORES*R_W-1:0] core_result_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [R_W-1:0]           result_out,
    output logic [PW-1:0]            result_core_id
`ifdef STC_DISPATCH_PERF_EN
    ,
    output logic [31:0]              perf_tiles,
    output logic [31:0]              perf_stall
`endif
);

    localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
    localparam logic [OW-1:0] OMAX = OW'(NUM_CORES);

    typedef enum logic [1:0] {IDLE, START, FETCH, DONE} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        dptr_q, dptr_d, rptr_q, rptr_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [NUM_CORES-1:0] load_q, load_d, ack_q, ack_d;
    logic [A_W-1:0]       a_q, a_d;
    logic [B_W-1:0]       b_q, b_d;
    logic [C_W-1:0]       c_q, c_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_CORES-1:0] dsel, rsel;
    logic                 can_go, beat_ok, last_beat, done, ov, rhs;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NUM_CORES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer decodes and handshake qualifiers
    always_comb begin
        dsel         = '0;
        rsel         = '0;
        dsel[dptr_q] = 1'b1;
        rsel[rptr_q] = 1'b1;
        can_go       = core_idle[dptr_q] && (outst_q < OMAX);
        beat_ok      = (state_q == FETCH) && core_fetch[dptr_q] && in_valid;
        last_beat    = (beat_q == BW'(FETCH_BEATS - 1));
        done         = (state_q == DONE);
        ov           = (outst_q != '0) && core_wb[rptr_q];
        rhs          = ov && out_ready;
    end

    // Dispatch FSM next state, beat counter and dispatch pointer
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        dptr_d  = dptr_q;
        unique case (state_q)
            IDLE: if (in_valid && can_go) state_d = START;
            START: begin
                state_d = FETCH;
                beat_d  = '0;
            end
            FETCH: begin
                if (beat_ok) begin
                    if (last_beat) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                dptr_d  = nxt(dptr_q);
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, load/ack pulses and result-side bookkeeping
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        idx_d  = idx_q;
        load_d = beat_ok ? dsel : '0;
        ack_d  = rhs ? rsel : '0;
        rptr_d = rhs ? nxt(rptr_q) : rptr_q;
        if (beat_ok) begin
            a_d   = a_data_in;
            b_d   = b_data_in;
            c_d   = c_data_in;
            idx_d = weight_idx_in;
        end
        case ({done, rhs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dptr_q  <= '0;
            rptr_q  <= '0;
            outst_q <= '0;
            beat_q  <= '0;
            load_q  <= '0;
            ack_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            rptr_q  <= rptr_d;
            outst_q <= outst_d;
            beat_q  <= beat_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are forced quiet while reset is held
    always_comb begin
        in_ready        = !rst && (state_q == FETCH) && core_fetch[dptr_q];
        core_start      = (!rst && state_q == START) ? dsel : '0;
        core_fetch_done = (!rst && done) ? dsel : '0;
        core_load       = rst ? '0 : load_q;
        core_wb_ack     = rst ? '0 : ack_q;
        a_data_out      = rst ? '0 : a_q;
        b_data_out      = rst ? '0 : b_q;
        c_data_out      = rst ? '0 : c_q;
        weight_idx_out  = rst ? '0 : idx_q;
        out_valid       = !rst && ov;
        result_out      = rst ? '0 : core_result_in[rptr_q*R_W +: R_W];
        result_core_id  = rst ? '0 : rptr_q;
    end

`ifdef STC_DISPATCH_PERF_EN
    logic [31:0] ptiles_q, ptiles_d, pstall_q, pstall_d;
    logic        stall;

    // Saturating tile and blocked-dispatch counters
    always_comb begin
        stall    = (state_q == IDLE) && in_valid && !can_go;
        ptiles_d = ptiles_q;
        pstall_d = pstall_q;
        if (done && !(&ptiles_q)) ptiles_d = ptiles_q + 32'd1;
        if (stall && !(&pstall_q)) pstall_d = pstall_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptiles_q <= '0;
            pstall_q <= '0;
        end else begin
            ptiles_q <= ptiles_d;
            pstall_q <= pstall_d;
        end
    end

    assign perf_tiles = ptiles_q;
    assign perf_stall = pstall_q;
`endif

endmodule

// File: doc/stc_dispatch.md
STC_DISPATCH -- requirements
Module: stc_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4, number of sparse tensor cores served (legal 2..8).
REQ-002 Parameter A_W/B_W/C_W/IDX_W/R_W, defaults 512/256/512/128/512, operand A/B/C, weight-index and result widths.
REQ-003 Parameter FETCH_BEATS, default 1, input beats loaded per tile (legal 1..16).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 each  operand beat handshake.
REQ-007 a_data_in / b_data_in / c_data_in / weight_idx_in  in  A_W / B_W / C_W / IDX_W  operand beat.
REQ-008 core_idle / core_fetch / core_wb  in  NUM_CORES each  per-core idle, fetch and write-back state flags.
REQ-009 core_start / core_fetch_done / core_load / core_wb_ack  out  NUM_CORES each  per-core one-cycle pulses.
REQ-010 a_data_out / b_data_out / c_data_out / weight_idx_out  out  A_W / B_W / C_W / IDX_W  registered operand broadcast, qualified by core_load.
REQ-011 core_result_in  in  NUM_CORES*R_W  flattened core results, core k at bits [k*R_W +: R_W].
REQ-012 out_valid / out_ready  out / in  1 each  result handshake.
REQ-013 result_out  out  R_W  selected result; result_core_id  out  clog2(NUM_CORES)  source core.

Function
REQ-014 Dispatch FSM shall have states IDLE, START, FETCH, DONE.
REQ-015 IDLE->START when in_valid=1, core_idle[dptr]=1 and outstanding<NUM_CORES; otherwise stay in IDLE.
REQ-016 In START, core_start[dptr] shall be 1 for exactly one cycle; next state FETCH.
REQ-017 In FETCH, in_ready shall equal core_fetch[dptr]; each cycle with in_valid&in_ready is one accepted beat.
REQ-018 On each accepted beat, operands shall be registered onto the *_out buses, with core_load[dptr]=1 in the following cycle.
REQ-019 A beat counter shall count 0..FETCH_BEATS-1; the last accepted beat moves FETCH->DONE.
REQ-020 In DONE, core_fetch_done[dptr]=1 for one cycle, outstanding increments, dptr advances (NUM_CORES-1 wraps to 0), next state IDLE.
REQ-021 Minimum tile dispatch is FETCH_BEATS+3 cycles from in_valid seen in IDLE to the return to IDLE.
REQ-022 Results shall be returned in dispatch order via rptr: out_valid = (outstanding>0) & core_wb[rptr].
REQ-023 result_out = core_result_in slice rptr and result_core_id = rptr, combinationally from rptr.
REQ-024 On out_valid&out_ready, core_wb_ack[rptr] shall pulse for the next cycle, rptr shall advance with wrap, and outstanding shall decrement.
REQ-025 DONE and a result handshake in the same cycle shall leave outstanding unchanged.
REQ-026 outstanding (clog2(NUM_CORES+1) bits) shall never exceed NUM_CORES; dispatch stalls while full.
REQ-027 out_valid shall stay stable while out_ready=0; core_wb on a core other than rptr shall be ignored.

Reset
REQ-028 rst shall force FSM=IDLE, dptr=rptr=0, outstanding=0 and beat counter=0.
REQ-029 During and after rst, all pulses, in_ready, out_valid and the *_out buses shall be 0.
REQ-030 rst asserted mid-FETCH shall abandon the tile with no core_fetch_done pulse.

Configuration
REQ-031 With STC_DISPATCH_PERF_EN defined, 32-bit outputs perf_tiles and perf_stall shall exist.
REQ-032 perf_tiles shall count DONE cycles; perf_stall shall count cycles in IDLE with in_valid=1 but dispatch blocked.
REQ-033 Both counters shall saturate at all-ones and clear on rst.
REQ-034 Without STC_DISPATCH_PERF_EN, the ports and counters shall be absent and behaviour shall otherwise be identical.

Verification
REQ-035 NUM_CORES=4, FETCH_BEATS=1, cores always idle/fetching -> 4 tiles give core_start on cores 0,1,2,3, then stall with outstanding=4.
REQ-036 core_wb raised in order 2,0 with out_ready=1 -> no out_valid until core 0; results leave with core_id 0 then 2 (after 1), in dispatch order.
REQ-037 FETCH_BEATS=3, in_valid toggling every cycle -> exactly 3 core_load pulses, then a single core_fetch_done.
REQ-038 DONE and a result handshake in the same cycle at outstanding=2 -> outstanding stays 2.
REQ-039 rst for one cycle during FETCH beat 1 -> all outputs 0 next cycle, dptr=0, no core_fetch_done.
REQ-040 STC_DISPATCH_PERF_EN, 5 tiles with 7 blocked cycles -> perf_tiles=5, perf_stall=7.
